// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC and arbitrates redirect > stall > halt > advance.
// Define FETCH_PERF_CNT_EN to add saturating stall/redirect performance counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_1,
    output logic [11:0] address_imem,
    output logic        fetch_valid,
    output logic        fd_enable,
    output logic        fd_flush,
    output logic        dx_flush,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] redirect_count,
`endif
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] ST_BOOT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    logic [31:0] r_pc;
    logic [1:0]  r_state;

    logic [31:0] w_pc_next;
    logic [1:0]  w_state_next;
    logic        w_fetch_valid;
    logic        w_fd_enable;
    logic        w_fd_flush;
    logic        w_dx_flush;
    logic        w_take_stall;
    logic        w_take_redirect;

    assign pc_plus_1 = r_pc + 32'd1;

    always_comb begin
        w_pc_next       = r_pc;
        w_state_next    = r_state;
        w_fetch_valid   = 1'b0;
        w_fd_enable     = 1'b1;
        w_fd_flush      = 1'b1;
        w_dx_flush      = 1'b0;
        w_take_stall    = 1'b0;
        w_take_redirect = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (redirect) begin
                    // Stall/halt seen alongside a redirect belong to the wrong path.
                    w_pc_next       = redirect_pc;
                    w_dx_flush      = 1'b1;
                    w_take_redirect = 1'b1;
                end else if (stall) begin
                    w_fetch_valid = 1'b1;
                    w_fd_enable   = 1'b0;
                    w_fd_flush    = 1'b0;
                    w_take_stall  = 1'b1;
                end else if (halt) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_pc_next     = pc_plus_1;
                    w_fetch_valid = 1'b1;
                    w_fd_flush    = 1'b0;
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    w_pc_next       = redirect_pc;
                    w_state_next    = ST_RUN;
                    w_dx_flush      = 1'b1;
                    w_take_redirect = 1'b1;
                end
            end
            default: begin
                // BOOT, and recovery from the unused encoding.
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc    <= RESET_PC;
            r_state <= ST_BOOT;
        end else begin
            r_pc    <= w_pc_next;
            r_state <= w_state_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_redirect_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles   <= 32'd0;
            r_redirect_count <= 32'd0;
        end else begin
            if (w_take_stall && (r_stall_cycles != 32'hFFFF_FFFF))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_take_redirect && (r_redirect_count != 32'hFFFF_FFFF))
                r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign redirect_count = r_redirect_count;
`endif

    assign pc_out       = r_pc;
    assign address_imem = r_pc[11:0];
    assign fetch_valid  = w_fetch_valid;
    assign fd_enable    = w_fd_enable;
    assign fd_flush     = w_fd_flush;
    assign dx_flush     = w_dx_flush;
    assign fsm_state    = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: boot, stall, redirect, halt, wrap and async reset.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_1;
    logic [11:0] address_imem;
    logic        fetch_valid;
    logic        fd_enable;
    logic        fd_flush;
    logic        dx_flush;
    logic [1:0]  fsm_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] redirect_count;
`endif

    int n_pass;
    int n_total;

    fetch_sequencer #(.RESET_PC(32'd0)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .pc_out       (pc_out),
        .pc_plus_1    (pc_plus_1),
        .address_imem (address_imem),
        .fetch_valid  (fetch_valid),
        .fd_enable    (fd_enable),
        .fd_flush     (fd_flush),
        .dx_flush     (dx_flush),
`ifdef FETCH_PERF_CNT_EN
        .stall_cycles   (stall_cycles),
        .redirect_count (redirect_count),
`endif
        .fsm_state    (fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 32'd0;
        tick(); tick();
        n_total++; if (pc_out !== 32'd0) $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'd0); else n_pass++;
        n_total++; if (fsm_state !== 2'b00) $display("FAIL reset_state got=%b exp=00", fsm_state); else n_pass++;
        reset_n = 1'b1;
        #1;
        n_total++; if ({fetch_valid, fd_enable, fd_flush, dx_flush} !== 4'b0110)
            $display("FAIL boot_ctl got=%b exp=0110", {fetch_valid, fd_enable, fd_flush, dx_flush}); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++; if (pc_out !== i) $display("FAIL boot_seq_pc got=%h exp=%h", pc_out, i); else n_pass++;
            n_total++; if ({fsm_state, fetch_valid, fd_flush} !== 4'b0110)
                $display("FAIL boot_seq_ctl got=%b exp=0110", {fsm_state, fetch_valid, fd_flush}); else n_pass++;
        end
    endtask

    task automatic test_stall();
        tick(); tick();
        n_total++; if (pc_out !== 32'd5) $display("FAIL stall_start_pc got=%h exp=5", pc_out); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            #1;
            n_total++; if (pc_out !== 32'd5) $display("FAIL stall_pc got=%h exp=5", pc_out); else n_pass++;
            n_total++; if ({fetch_valid, fd_enable, fd_flush, dx_flush} !== 4'b1000)
                $display("FAIL stall_ctl got=%b exp=1000", {fetch_valid, fd_enable, fd_flush, dx_flush}); else n_pass++;
            tick();
        end
        stall = 1'b0;
        #1;
        n_total++; if ({pc_out, fd_enable} !== {32'd5, 1'b1})
            $display("FAIL stall_release got=%h/%b exp=5/1", pc_out, fd_enable); else n_pass++;
        tick();
        n_total++; if (pc_out !== 32'd6) $display("FAIL stall_resume got=%h exp=6", pc_out); else n_pass++;
    endtask

    task automatic test_redirect();
        tick(); tick(); tick(); tick();
        n_total++; if (pc_out !== 32'd10) $display("FAIL redir_start_pc got=%h exp=a", pc_out); else n_pass++;
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
        #1;
        n_total++; if ({fetch_valid, fd_enable, fd_flush, dx_flush} !== 4'b0111)
            $display("FAIL redir_ctl got=%b exp=0111", {fetch_valid, fd_enable, fd_flush, dx_flush}); else n_pass++;
        tick();
        redirect = 1'b0; stall = 1'b0;
        #1;
        n_total++; if (pc_out !== 32'h40) $display("FAIL redir_pc got=%h exp=40", pc_out); else n_pass++;
        n_total++; if ({fsm_state, fetch_valid} !== 3'b011) $display("FAIL redir_valid got=%b exp=011", {fsm_state, fetch_valid}); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
        n_total++; if (stall_cycles !== 32'd3) $display("FAIL perf_stall got=%0d exp=3", stall_cycles); else n_pass++;
        n_total++; if (redirect_count !== 32'd1) $display("FAIL perf_redir got=%0d exp=1", redirect_count); else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_pc = 32'h200;
        #1;
        n_total++; if ({pc_out, fetch_valid} !== {32'h100, 1'b0})
            $display("FAIL b2b_first got=%h/%b exp=100/0", pc_out, fetch_valid); else n_pass++;
        tick();
        redirect = 1'b0;
        #1;
        n_total++; if ({pc_out, fetch_valid} !== {32'h200, 1'b1})
            $display("FAIL b2b_second got=%h/%b exp=200/1", pc_out, fetch_valid); else n_pass++;
    endtask

    task automatic test_halt();
        redirect = 1'b1; redirect_pc = 32'd20;
        tick();
        redirect = 1'b0; halt = 1'b1;
        #1;
        n_total++; if ({pc_out, fetch_valid, fd_enable, fd_flush, dx_flush} !== {32'd20, 4'b0110})
            $display("FAIL halt_entry got=%h/%b exp=14/0110", pc_out, {fetch_valid, fd_enable, fd_flush, dx_flush}); else n_pass++;
        tick();
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            #1;
            n_total++; if ({fsm_state, pc_out, fetch_valid, fd_flush, dx_flush} !== {2'b10, 32'd20, 3'b010})
                $display("FAIL halt_hold got=%b/%h/%b exp=10/14/010", fsm_state, pc_out, {fetch_valid, fd_flush, dx_flush}); else n_pass++;
            tick();
        end
        stall = 1'b0; halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h8;
        #1;
        n_total++; if ({fetch_valid, fd_flush, dx_flush} !== 3'b011)
            $display("FAIL halt_redir_ctl got=%b exp=011", {fetch_valid, fd_flush, dx_flush}); else n_pass++;
        tick();
        redirect = 1'b0;
        #1;
        n_total++; if ({fsm_state, pc_out, fetch_valid} !== {2'b01, 32'h8, 1'b1})
            $display("FAIL halt_exit got=%b/%h/%b exp=01/8/1", fsm_state, pc_out, fetch_valid); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
        n_total++; if (redirect_count !== 32'd5) $display("FAIL perf_redir_halt got=%0d exp=5", redirect_count); else n_pass++;
`endif
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        #1;
        n_total++; if ({pc_plus_1, address_imem} !== {32'd0, 12'hFFF})
            $display("FAIL wrap_plus1 got=%h/%h exp=0/fff", pc_plus_1, address_imem); else n_pass++;
        tick();
        n_total++; if ({pc_out, address_imem} !== {32'd0, 12'h000})
            $display("FAIL wrap_pc got=%h/%h exp=0/000", pc_out, address_imem); else n_pass++;
        redirect = 1'b1; redirect_pc = 32'hFFF;
        tick();
        redirect = 1'b0;
        #1;
        n_total++; if (pc_plus_1 !== 32'h1000) $display("FAIL imem_plus1 got=%h exp=1000", pc_plus_1); else n_pass++;
        tick();
        n_total++; if ({pc_out, address_imem} !== {32'h1000, 12'h000})
            $display("FAIL imem_trunc got=%h/%h exp=1000/000", pc_out, address_imem); else n_pass++;
    endtask

    task automatic test_async_reset();
        redirect = 1'b1; redirect_pc = 32'h33;
        tick();
        redirect = 1'b0; stall = 1'b1;
        tick();
        n_total++; if (pc_out !== 32'h33) $display("FAIL areset_pre got=%h exp=33", pc_out); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++; if ({pc_out, fsm_state} !== {32'd0, 2'b00})
            $display("FAIL areset_state got=%h/%b exp=0/00", pc_out, fsm_state); else n_pass++;
        n_total++; if ({fetch_valid, fd_enable, fd_flush, dx_flush} !== 4'b0110)
            $display("FAIL areset_ctl got=%b exp=0110", {fetch_valid, fd_enable, fd_flush, dx_flush}); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
        n_total++; if ({stall_cycles, redirect_count} !== 64'd0)
            $display("FAIL areset_perf got=%0d/%0d exp=0/0", stall_cycles, redirect_count); else n_pass++;
`endif
        tick();
        stall = 1'b0; reset_n = 1'b1;
        tick();
        tick();
        n_total++; if ({fsm_state, pc_out, fetch_valid} !== {2'b01, 32'd1, 1'b1})
            $display("FAIL areset_resume got=%b/%h/%b exp=01/1/1", fsm_state, pc_out, fetch_valid); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequencing controller for the fetch stage: owns the program-counter register and decides each cycle whether the PC advances, holds, or is redirected. It drives the instruction-memory address and the F/D pipeline latch enable/flush controls, and resolves redirect, stall and halt events with a fixed priority. It sits between the hazard unit, the execute-stage branch resolution and the F/D latch.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit requests fetch hold (load-use etc.).
- redirect  in  1  execute stage resolved a taken branch/jump this cycle.
- redirect_pc  in  32  target PC, valid when redirect=1.
- halt  in  1  decode stage holds a halt instruction.
- pc_out  out  32  PC register: address of instruction fetched this cycle.
- pc_plus_1  out  32  pc_out + 1, mod 2^32.
- address_imem  out  12  pc_out[11:0].
- fetch_valid  out  1  instruction at pc_out is on the correct path and usable.
- fd_enable  out  1  F/D latch write enable.
- fd_flush  out  1  F/D latch loads a nop instead of the imem word.
- dx_flush  out  1  D/X latch loads a nop.
- fsm_state  out  2  debug: 00 BOOT, 01 RUN, 10 HALT.

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT.
- BOOT (exactly one cycle): pc holds; fetch_valid=0, fd_enable=1, fd_flush=1, dx_flush=0; next RUN. Inputs ignored.
- RUN, priority redirect > stall > halt > advance:
  - redirect: pc <= redirect_pc; fetch_valid=0, fd_enable=1, fd_flush=1, dx_flush=1; stay RUN. Concurrent stall/halt dropped (wrong-path).
  - stall: pc holds; fetch_valid=1, fd_enable=0, flushes 0.
  - halt: pc holds; fetch_valid=0, fd_enable=1, fd_flush=1; next HALT.
  - none: pc <= pc_plus_1; fetch_valid=1, fd_enable=1, flushes 0.
- HALT: pc holds; fetch_valid=0, fd_enable=1, fd_flush=1, dx_flush=0. stall and halt ignored. redirect: same outputs and pc update as RUN-redirect, next RUN (halt was wrong-path). Only reset otherwise exits.
- Arithmetic: pc_plus_1 wraps 32'hFFFFFFFF -> 0. address_imem is truncation; pc 0x00000FFF -> 0x00001000 gives address 0x000.
- redirect_pc is used unmodified; no alignment or range check.

## Timing
- pc_out, fsm_state registered. All other outputs combinational from state, pc_out and inputs (same cycle).
- Reset (async assert, any cycle, mid-operation included): pc_out=RESET_PC, fsm_state=BOOT immediately; outputs therefore fetch_valid=0, fd_enable=1, fd_flush=1, dx_flush=0. Deassertion synchronous to design intent; first rising edge after release leaves BOOT.
- First valid fetch: second rising edge after reset release sees fetch_valid=1 at RESET_PC.
- Redirect latency: redirect at cycle t -> pc_out=redirect_pc, fetch_valid=1 at t+1 (no extra bubble).
- Stall holds for as many cycles as asserted; pc_out unchanged, advance resumes the cycle after stall drops.
- halt at t -> HALT at t+1; pc_out frozen at the value from cycle t.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] and redirect_count[31:0], registered, reset to 0. stall_cycles increments each RUN cycle taking the stall branch; redirect_count increments each cycle a redirect is taken (RUN or HALT). Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset release, no events, RESET_PC=0 -> cycle 1 BOOT (fetch_valid=0, fd_flush=1), then pc_out 0,1,2,3 with fetch_valid=1.
- RUN at pc=5, stall 3 cycles -> pc_out stays 5, fd_enable=0 for 3 cycles, then 6.
- pc=10, redirect=1 with stall=1 and redirect_pc=0x40 -> fd_flush=dx_flush=1 that cycle, next pc_out=0x40, fetch_valid=1; stall_cycles unchanged, redirect_count=1 (macro on).
- halt at pc=20 -> HALT, pc_out stays 20 for 10 cycles, fetch_valid=0; then redirect to 0x8 -> RUN, pc_out=8.
- Load pc 0xFFFFFFFF via redirect, advance -> pc_out=0, address_imem=0x000; pc 0xFFF advance -> address_imem=0x000, pc_out=0x1000.
- Assert reset_n low mid-stall at pc=0x33 -> pc_out=0, fsm_state=00 without waiting for a clock edge; counters cleared.
